// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between fetch/execute and the branch resolve queue.
// The master modport is the pipeline side and the slave modport is the queue itself.
interface branch_resolve_queue_if #(
  parameter int DEPTH          = 4,
  parameter int BHT_INDEX_BITS = 3,
  parameter int PHT_INDEX_BITS = 7
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                      enq_valid;
  logic                      enq_ready;
  logic [31:0]               enq_pc;
  logic                      enq_pred_taken;
  logic [31:0]               enq_pred_target;
  logic [BHT_INDEX_BITS-1:0] enq_bht_index;
  logic [PHT_INDEX_BITS-1:0] enq_pht_index;

  logic                      res_valid;
  logic                      res_taken;
  logic [31:0]               res_target;
  logic                      flush;

  logic                      redirect_valid;
  logic [31:0]               redirect_pc;

  logic                      upd_valid;
  logic [BHT_INDEX_BITS-1:0] upd_bht_index;
  logic [PHT_INDEX_BITS-1:0] upd_pht_index;
  logic                      upd_taken;
  logic                      upd_correct;

  logic                      res_error;
  logic [CNT_W-1:0]          count;

  modport master (
    output enq_valid, enq_pc, enq_pred_taken, enq_pred_target, enq_bht_index, enq_pht_index,
    output res_valid, res_taken, res_target, flush,
    input  enq_ready, redirect_valid, redirect_pc,
    input  upd_valid, upd_bht_index, upd_pht_index, upd_taken, upd_correct,
    input  res_error, count
  );

  modport slave (
    input  enq_valid, enq_pc, enq_pred_taken, enq_pred_target, enq_bht_index, enq_pht_index,
    input  res_valid, res_taken, res_target, flush,
    output enq_ready, redirect_valid, redirect_pc,
    output upd_valid, upd_bht_index, upd_pht_index, upd_taken, upd_correct,
    output res_error, count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions with mispredict redirect and predictor training.
// Optional BRQ_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_queue #(
  parameter int DEPTH          = 4,
  parameter int BHT_INDEX_BITS = 3,
  parameter int PHT_INDEX_BITS = 7
) (
  input logic                   clk,
  input logic                   rst,
  branch_resolve_queue_if.slave brq
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]           stat_resolved,
  output logic [31:0]           stat_mispredict
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]               pc_mem     [DEPTH];
  logic                      taken_mem  [DEPTH];
  logic [31:0]               target_mem [DEPTH];
  logic [BHT_INDEX_BITS-1:0] bht_mem    [DEPTH];
  logic [PHT_INDEX_BITS-1:0] pht_mem    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_next;
  logic [CNT_W-1:0] occ;
  logic             enq_fire;
  logic             res_fire;
  logic             mispredict;

  assign brq.enq_ready = (occ != FULL);
  assign brq.count     = occ;
  assign enq_fire      = brq.enq_valid && brq.enq_ready;
  assign res_fire      = brq.res_valid && (occ != '0);
  assign head_next     = head + PTR_W'(1);

  // Target only matters when both the prediction and the outcome say taken.
  assign mispredict = (taken_mem[head] != brq.res_taken) ||
                      (taken_mem[head] && brq.res_taken && (target_mem[head] != brq.res_target));

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]     <= '0;
        taken_mem[i]  <= 1'b0;
        target_mem[i] <= '0;
        bht_mem[i]    <= '0;
        pht_mem[i]    <= '0;
      end
    end else if (brq.flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (res_fire && mispredict) begin
      // Everything younger is wrong-path, including a same-cycle enqueue.
      head <= head_next;
      tail <= head_next;
      occ  <= '0;
    end else begin
      if (enq_fire) begin
        pc_mem[tail]     <= brq.enq_pc;
        taken_mem[tail]  <= brq.enq_pred_taken;
        target_mem[tail] <= brq.enq_pred_target;
        bht_mem[tail]    <= brq.enq_bht_index;
        pht_mem[tail]    <= brq.enq_pht_index;
        tail             <= tail + PTR_W'(1);
      end
      if (res_fire) begin
        head <= head_next;
      end
      case ({enq_fire, res_fire})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Pulses follow the resolve regardless of flush; data fields hold between resolves.
  always_ff @(posedge clk) begin
    if (rst) begin
      brq.upd_valid      <= 1'b0;
      brq.upd_bht_index  <= '0;
      brq.upd_pht_index  <= '0;
      brq.upd_taken      <= 1'b0;
      brq.upd_correct    <= 1'b0;
      brq.redirect_valid <= 1'b0;
      brq.redirect_pc    <= '0;
      brq.res_error      <= 1'b0;
    end else begin
      brq.upd_valid      <= res_fire;
      brq.redirect_valid <= res_fire && mispredict;
      brq.res_error      <= brq.res_valid && (occ == '0);
      if (res_fire) begin
        brq.upd_bht_index <= bht_mem[head];
        brq.upd_pht_index <= pht_mem[head];
        brq.upd_taken     <= brq.res_taken;
        brq.upd_correct   <= !mispredict;
        if (mispredict) begin
          brq.redirect_pc <= brq.res_taken ? brq.res_target : (pc_mem[head] + 32'd8);
        end
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (brq.upd_valid && (stat_resolved != 32'hFFFF_FFFF)) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if (brq.redirect_valid && (stat_mispredict != 32'hFFFF_FFFF)) begin
        stat_mispredict <= stat_mispredict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed vector table, wrap sequence,
// and randomized traffic compared against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int BHT   = 3;
  localparam int PHT   = 7;

  typedef struct {
    logic            enq_valid;
    logic [31:0]     pc;
    logic            pt;
    logic [31:0]     ptgt;
    logic [BHT-1:0]  bht;
    logic [PHT-1:0]  pht;
    logic            res_valid;
    logic            rt;
    logic [31:0]     rtgt;
    logic            flush;
  } stim_t;

  typedef struct {
    logic [31:0]     pc;
    logic            pt;
    logic [31:0]     ptgt;
    logic [BHT-1:0]  bht;
    logic [PHT-1:0]  pht;
  } entry_t;

  typedef struct {
    stim_t       s;
    int          exp_count;
    bit          exp_ready;
    bit          exp_upd;
    bit          exp_correct;
    bit          exp_redir;
    logic [31:0] exp_rpc;
    bit          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.DEPTH(DEPTH), .BHT_INDEX_BITS(BHT), .PHT_INDEX_BITS(PHT)) brq();

`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
`endif

  branch_resolve_queue #(.DEPTH(DEPTH), .BHT_INDEX_BITS(BHT), .PHT_INDEX_BITS(PHT)) dut (
    .clk(clk),
    .rst(rst),
    .brq(brq)
`ifdef BRQ_STATS_EN
    ,
    .stat_resolved(stat_resolved),
    .stat_mispredict(stat_mispredict)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural queue contents plus expected registered outputs.
  entry_t          mq[$];
  logic            m_upd_valid;
  logic [BHT-1:0]  m_upd_bht;
  logic [PHT-1:0]  m_upd_pht;
  logic            m_upd_taken;
  logic            m_upd_correct;
  logic            m_redir_valid;
  logic [31:0]     m_redir_pc;
  logic            m_res_error;

  vec_t vecs[$];

  function automatic stim_t mk(logic ev, logic [31:0] pc, logic pt, logic [31:0] ptgt,
                               int bht, int pht, logic rv, logic rt, logic [31:0] rtgt,
                               logic fl);
    stim_t s;
    s.enq_valid = ev;
    s.pc        = pc;
    s.pt        = pt;
    s.ptgt      = ptgt;
    s.bht       = BHT'(bht);
    s.pht       = PHT'(pht);
    s.res_valid = rv;
    s.rt        = rt;
    s.rtgt      = rtgt;
    s.flush     = fl;
    return s;
  endfunction

  task automatic addVec(stim_t s, int c, bit r, bit u, bit cor, bit rd, logic [31:0] rpc, bit err);
    vec_t v;
    v.s           = s;
    v.exp_count   = c;
    v.exp_ready   = r;
    v.exp_upd     = u;
    v.exp_correct = cor;
    v.exp_redir   = rd;
    v.exp_rpc     = rpc;
    v.exp_err     = err;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(stim_t s);
    brq.enq_valid       = s.enq_valid;
    brq.enq_pc          = s.pc;
    brq.enq_pred_taken  = s.pt;
    brq.enq_pred_target = s.ptgt;
    brq.enq_bht_index   = s.bht;
    brq.enq_pht_index   = s.pht;
    brq.res_valid       = s.res_valid;
    brq.res_taken       = s.rt;
    brq.res_target      = s.rtgt;
    brq.flush           = s.flush;
  endtask

  task automatic modelClear();
    mq.delete();
    m_upd_valid   = 0;
    m_upd_bht     = '0;
    m_upd_pht     = '0;
    m_upd_taken   = 0;
    m_upd_correct = 0;
    m_redir_valid = 0;
    m_redir_pc    = '0;
    m_res_error   = 0;
  endtask

  // One clock of the architectural rules, evaluated on the pre-edge model state.
  task automatic modelStep(stim_t s);
    bit     accept;
    bit     resolving;
    bit     wrong;
    entry_t e;
    entry_t n;
    accept      = s.enq_valid && (mq.size() < DEPTH);
    resolving   = s.res_valid && (mq.size() > 0);
    m_res_error = s.res_valid && (mq.size() == 0);
    m_upd_valid = resolving;
    wrong       = 0;
    m_redir_valid = 0;
    if (resolving) begin
      e = mq[0];
      if (e.pt != s.rt) wrong = 1;
      else if (e.pt && e.ptgt != s.rtgt) wrong = 1;
      m_upd_bht     = e.bht;
      m_upd_pht     = e.pht;
      m_upd_taken   = s.rt;
      m_upd_correct = !wrong;
      if (wrong) begin
        m_redir_valid = 1;
        m_redir_pc    = s.rt ? s.rtgt : e.pc + 32'd8;
      end
    end
    if (s.flush || wrong) begin
      mq.delete();
    end else begin
      if (resolving) void'(mq.pop_front());
      if (accept) begin
        n.pc   = s.pc;
        n.pt   = s.pt;
        n.ptgt = s.ptgt;
        n.bht  = s.bht;
        n.pht  = s.pht;
        mq.push_back(n);
      end
    end
  endtask

  task automatic checkModel(string tag);
    checkOutput({tag, "_count"},       32'(brq.count),          mq.size());
    checkOutput({tag, "_enq_ready"},   32'(brq.enq_ready),      32'(mq.size() < DEPTH));
    checkOutput({tag, "_upd_valid"},   32'(brq.upd_valid),      32'(m_upd_valid));
    checkOutput({tag, "_upd_bht"},     32'(brq.upd_bht_index),  32'(m_upd_bht));
    checkOutput({tag, "_upd_pht"},     32'(brq.upd_pht_index),  32'(m_upd_pht));
    checkOutput({tag, "_upd_taken"},   32'(brq.upd_taken),      32'(m_upd_taken));
    checkOutput({tag, "_upd_correct"}, 32'(brq.upd_correct),    32'(m_upd_correct));
    checkOutput({tag, "_redir_valid"}, 32'(brq.redirect_valid), 32'(m_redir_valid));
    checkOutput({tag, "_redir_pc"},    brq.redirect_pc,         m_redir_pc);
    checkOutput({tag, "_res_error"},   32'(brq.res_error),      32'(m_res_error));
  endtask

  task automatic applyStimulus(stim_t s, string tag);
    @(negedge clk);
    driveInputs(s);
    modelStep(s);
    @(posedge clk);
    #1;
    checkModel(tag);
  endtask

  task automatic applyReset(bit with_res);
    @(negedge clk);
    rst = 1'b1;
    driveInputs(mk(with_res, 32'h0, 0, 32'h0, 0, 0, with_res, 1, 32'h1234, 0));
    @(posedge clk);
    #1;
    modelClear();
    checkModel("reset");
    rst = 1'b0;
    driveInputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic stim_t randStim();
    stim_t s;
    s.enq_valid = ($urandom_range(0, 9) < 6);
    s.pc        = $urandom();
    s.pt        = 1'($urandom_range(0, 1));
    s.ptgt      = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000;
    s.bht       = BHT'($urandom());
    s.pht       = PHT'($urandom());
    s.res_valid = ($urandom_range(0, 9) < 4);
    s.rt        = 1'($urandom_range(0, 1));
    s.rtgt      = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000;
    s.flush     = ($urandom_range(0, 24) == 0);
    return s;
  endfunction

  initial begin
    rst = 1'b1;
    driveInputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    modelClear();

    //      ev  pc            pt ptgt          bht pht   rv rt rtgt          fl   cnt rdy upd cor rd rpc           err
    addVec(mk(1, 32'h100,      0, 32'h0,       1, 8'h10, 0, 0, 32'h0,   0),  1, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h110,      0, 32'h0,       2, 8'h11, 0, 0, 32'h0,   0),  2, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h120,      0, 32'h0,       3, 8'h12, 0, 0, 32'h0,   0),  3, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h130,      0, 32'h0,       4, 8'h13, 0, 0, 32'h0,   0),  4, 0, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h140,      0, 32'h0,       5, 8'h14, 0, 0, 32'h0,   0),  4, 0, 0, 0, 0, 32'h0,   0);
    addVec(mk(0, 32'h0,        0, 32'h0,       0, 0,     1, 0, 32'h0,   0),  3, 1, 1, 1, 0, 32'h0,   0);
    addVec(mk(1, 32'h150,      0, 32'h0,       6, 8'h15, 1, 0, 32'h0,   0),  3, 1, 1, 1, 0, 32'h0,   0);
    addVec(mk(0, 32'h0,        0, 32'h0,       0, 0,     1, 1, 32'h600, 0),  0, 1, 1, 0, 1, 32'h600, 0);
    addVec(mk(1, 32'h180,      1, 32'h200,     3, 8'h45, 0, 0, 32'h0,   0),  1, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(0, 32'h0,        0, 32'h0,       0, 0,     1, 1, 32'h200, 0),  0, 1, 1, 1, 0, 32'h0,   0);
    addVec(mk(1, 32'h400,      1, 32'h480,     1, 8'h20, 0, 0, 32'h0,   0),  1, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h410,      0, 32'h0,       2, 8'h21, 0, 0, 32'h0,   0),  2, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h420,      0, 32'h0,       3, 8'h22, 0, 0, 32'h0,   0),  3, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(0, 32'h0,        0, 32'h0,       0, 0,     1, 0, 32'h0,   0),  0, 1, 1, 0, 1, 32'h408, 0);
    addVec(mk(1, 32'h4f0,      1, 32'h500,     5, 8'h30, 0, 0, 32'h0,   0),  1, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h600,      0, 32'h0,       6, 8'h31, 1, 1, 32'h540, 0),  0, 1, 1, 0, 1, 32'h540, 0);
    addVec(mk(0, 32'h0,        0, 32'h0,       0, 0,     1, 0, 32'h0,   0),  0, 1, 0, 0, 0, 32'h0,   1);
    addVec(mk(1, 32'h700,      0, 32'h0,       1, 8'h40, 0, 0, 32'h0,   0),  1, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h710,      0, 32'h0,       1, 8'h41, 0, 0, 32'h0,   0),  2, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h720,      0, 32'h0,       1, 8'h42, 0, 0, 32'h0,   0),  3, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h730,      0, 32'h0,       1, 8'h43, 0, 0, 32'h0,   1),  0, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(1, 32'h800,      0, 32'h0,       2, 8'h50, 0, 0, 32'h0,   0),  1, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(0, 32'h0,        0, 32'h0,       0, 0,     1, 1, 32'h900, 1),  0, 1, 1, 0, 1, 32'h900, 0);
    addVec(mk(1, 32'hFFFFFFFC, 1, 32'h10,      7, 8'h7F, 0, 0, 32'h0,   0),  1, 1, 0, 0, 0, 32'h0,   0);
    addVec(mk(0, 32'h0,        0, 32'h0,       0, 0,     1, 0, 32'h0,   0),  0, 1, 1, 0, 1, 32'h4,   0);

    repeat (2) @(posedge clk);
    applyReset(0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].s, tag);
      checkOutput({tag, "_tbl_count"}, 32'(brq.count), vecs[i].exp_count);
      checkOutput({tag, "_tbl_ready"}, 32'(brq.enq_ready), 32'(vecs[i].exp_ready));
      checkOutput({tag, "_tbl_upd"},   32'(brq.upd_valid), 32'(vecs[i].exp_upd));
      checkOutput({tag, "_tbl_redir"}, 32'(brq.redirect_valid), 32'(vecs[i].exp_redir));
      checkOutput({tag, "_tbl_err"},   32'(brq.res_error), 32'(vecs[i].exp_err));
      if (vecs[i].exp_upd) checkOutput({tag, "_tbl_correct"}, 32'(brq.upd_correct), 32'(vecs[i].exp_correct));
      if (vecs[i].exp_redir) checkOutput({tag, "_tbl_rpc"}, brq.redirect_pc, vecs[i].exp_rpc);
    end

    // Wrap: three entries in flight, then steady enqueue+correct resolve past the end of storage.
    applyReset(0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mk(1, 32'h1000 + 32'(k * 4), 0, 32'h0, k, k, 0, 0, 32'h0, 0), "wrap_fill");
    end
    for (int k = 0; k < 10; k++) begin
      applyStimulus(mk(1, 32'h1000 + 32'((k + 3) * 4), 0, 32'h0, k + 3, k + 3, 1, 0, 32'h0, 0), "wrap");
      checkOutput($sformatf("wrap%0d_pht_order", k), 32'(brq.upd_pht_index), k);
      checkOutput($sformatf("wrap%0d_count", k), 32'(brq.count), 3);
      checkOutput($sformatf("wrap%0d_correct", k), 32'(brq.upd_correct), 1);
    end

    // Reset arriving while a resolve is in flight must kill the pulse.
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h3000, 0), "pre_reset_res");
    applyReset(1);
    checkOutput("reset_kills_upd", 32'(brq.upd_valid), 0);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) applyReset(1);
      applyStimulus(randStim(), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions, one entry per predicted branch.
- Fetch pushes prediction metadata into the queue. Execute resolves the oldest entry against the actual outcome.
- The block raises a registered redirect on mispredict and flushes younger entries.
- One cycle after resolution, the block drives the predictor's training port: valid, BHT index, PHT index, taken, correct.

Parameters:
- DEPTH, 4, number of entries; power of 2, at least 2.
- BHT_INDEX_BITS, 3, width of the BHT index carried per entry.
- PHT_INDEX_BITS, 7, width of the PHT index carried per entry.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enq_valid  in  1  fetch has a branch with a prediction to record.
- enq_ready  out  1  queue can accept an entry; equals !full.
- enq_pc  in  32  branch PC.
- enq_pred_taken  in  1  predicted direction.
- enq_pred_target  in  32  predicted target; only meaningful when enq_pred_taken=1.
- enq_bht_index  in  BHT_INDEX_BITS  BHT index used for the prediction.
- enq_pht_index  in  PHT_INDEX_BITS  PHT index used for the prediction.
- res_valid  in  1  execute resolves the oldest branch this cycle.
- res_taken  in  1  actual direction.
- res_target  in  32  actual taken target.
- flush  in  1  exception/external flush; clears all entries.
- redirect_valid  out  1  one-cycle pulse on mispredict.
- redirect_pc  out  32  correct fetch PC.
- upd_valid  out  1  one-cycle training pulse.
- upd_bht_index  out  BHT_INDEX_BITS  index to train.
- upd_pht_index  out  PHT_INDEX_BITS  index to train.
- upd_taken  out  1  actual direction.
- upd_correct  out  1  prediction matched.
- res_error  out  1  one-cycle pulse: res_valid while queue empty.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer, head (oldest) and tail pointers of $clog2(DEPTH) bits each, wrap modulo DEPTH. Occupancy counter is 0..DEPTH.
- Reset: pointers=0, count=0, enq_ready=1. redirect_valid, upd_valid and res_error=0. redirect_pc, upd_* data and entry contents=0.
- Enqueue: write at tail when enq_valid && enq_ready. enq_ready is computed from the registered count; no same-cycle dequeue bypass, so when full, enq is refused even if a resolve occurs that cycle.
- Resolve: when res_valid && count>0, read entry at head and advance head.
  - Mispredict condition: pred_taken != res_taken, or (both taken && pred_target != res_target).
  - Pointer and count updates happen in the same cycle as the resolve.
- Registered outputs, next cycle after a resolve:
  - upd_valid=1, with upd_bht_index and upd_pht_index from the entry.
  - upd_taken=res_taken; upd_correct = !mispredict.
  - If mispredict: redirect_valid=1 and redirect_pc = res_taken ? res_target : entry_pc+8 (branch plus delay slot; 32-bit wrap).
- Mispredict flush: in the resolve cycle, all younger entries are discarded (tail=new head, count=0). A same-cycle enqueue is wrong-path and is dropped.
- Correct resolve with same-cycle enqueue: count unchanged, both pointers advance.
- Empty resolve: res_valid with count=0 gives res_error=1 next cycle. No state change, no upd or redirect pulse.
- flush: pointers and count cleared next edge, and same-cycle enq is dropped. flush has priority over enq and over the queue-state effects of res. A res in the same cycle as flush still produces its upd/redirect pulses, because it was resolved from valid state.
- Reset mid-operation clears everything, including any pending upd or redirect pulse.
- All outputs are registered except enq_ready and count.

Optional Feature:
- Macro: BRQ_STATS_EN.
- Enabled:
  - Extra outputs stat_resolved[31:0] and stat_mispredict[31:0], both saturating at 32'hFFFFFFFF.
  - Counters increment on each upd_valid pulse and each redirect_valid pulse respectively.
  - Both cleared by rst.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fill: four enq with pc 0x100/0x110/0x120/0x130 and no res -> count=4, enq_ready=0. A fifth enq is ignored and count stays 4.
- Correct resolve: entry pred_taken=1, pred_target=0x200, bht=3, pht=0x45; res_taken=1, res_target=0x200 -> next cycle upd_valid=1, upd_bht_index=3, upd_pht_index=0x45, upd_taken=1, upd_correct=1, redirect_valid=0.
- Not-taken mispredict: entry pc=0x400, pred_taken=1; res_taken=0 with 2 younger entries queued -> redirect_valid=1, redirect_pc=0x408, upd_correct=0, count=0.
- Target mispredict: pred 0x500, actual 0x540, same-cycle enq -> redirect_pc=0x540, the enq is dropped, count=0.
- Wrap and simultaneous traffic: 10 cycles of simultaneous enq and correct res at DEPTH=4 -> FIFO order preserved across wrap, count constant.
- Empty resolve, then flush: res_valid with count=0 -> res_error=1, no upd. Next, flush with 3 entries queued and enq_valid=1 -> count=0 next cycle.
